// File: rtl/if_scratchpad_if.sv
// Bus between the IF scratchpad and its neighbours.
// The write side comes from the input FIFO, the read side from the IF address
// generator, and row release comes from the controller.
// master = environment side, slave = scratchpad side.
interface if_scratchpad_if #(
    parameter int DATA_WIDTH      = 16,
    parameter int POINTER_SIZE    = 8,
    parameter int ROW_QUEUE_DEPTH = 4
);
    // write stream
    logic                              wr_valid;
    logic [DATA_WIDTH-1:0]             wr_data;
    logic                              wr_last;
    logic                              wr_ready;
    // read port
    logic                              rd_en;
    logic [POINTER_SIZE-1:0]           read_pointer;
    logic [DATA_WIDTH-1:0]             rd_data;
    logic                              rd_valid;
    // row bookkeeping
    logic                              release_row;
    logic [POINTER_SIZE-1:0]           start_row;
    logic [POINTER_SIZE-1:0]           end_row;
    logic                              row_ready;
    logic [$clog2(ROW_QUEUE_DEPTH):0]  rows_stored;
    logic                              err_release;

    modport master (
        output wr_valid, wr_data, wr_last, rd_en, read_pointer, release_row,
        input  wr_ready, rd_data, rd_valid, start_row, end_row, row_ready,
               rows_stored, err_release
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, rd_en, read_pointer, release_row,
        output wr_ready, rd_data, rd_valid, start_row, end_row, row_ready,
               rows_stored, err_release
    );
endinterface

// File: rtl/if_scratchpad.sv
// Circular input-feature scratchpad.
// Stores IF words row by row in a wrap-around buffer and tracks complete-row
// boundaries in a small queue of row-end pointers. The oldest complete row is
// exported as start_row/end_row until the controller releases it.
// Reads return registered data one cycle after rd_en.
module if_scratchpad #(
    parameter int DATA_WIDTH      = 16,
    parameter int POINTER_SIZE    = 8,
    parameter int ROW_QUEUE_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    if_scratchpad_if.slave bus
);

    localparam int DEPTH = 2 ** POINTER_SIZE;
    // Queue index width; kept at least one bit so a single-entry queue still elaborates.
    localparam int QW    = (ROW_QUEUE_DEPTH > 1) ? $clog2(ROW_QUEUE_DEPTH) : 1;
    localparam int RW    = $clog2(ROW_QUEUE_DEPTH) + 1;

    localparam logic [POINTER_SIZE:0]   DEPTH_C = (POINTER_SIZE + 1)'(DEPTH);
    localparam logic [POINTER_SIZE:0]   CNT_ONE = (POINTER_SIZE + 1)'(1);
    localparam logic [POINTER_SIZE-1:0] PTR_ONE = POINTER_SIZE'(1);
    localparam logic [RW-1:0]           RQD_C   = RW'(ROW_QUEUE_DEPTH);
    localparam logic [RW-1:0]           ROW_ONE = RW'(1);
    localparam logic [QW-1:0]           Q_LAST  = QW'(ROW_QUEUE_DEPTH - 1);
    localparam logic [QW-1:0]           Q_ONE   = QW'(1);

    // storage
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    // write side
    logic [POINTER_SIZE-1:0] r_wp;
    logic [POINTER_SIZE:0]   r_cnt;

    // row bookkeeping: start of oldest row plus a FIFO of row-end addresses
    logic [POINTER_SIZE-1:0] r_start;
    logic [POINTER_SIZE-1:0] r_rq [ROW_QUEUE_DEPTH];
    logic [QW-1:0]           r_head;
    logic [QW-1:0]           r_tail;
    logic [RW-1:0]           r_rows;
    logic                    r_err;

    // read side
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_rd_valid;

    logic [POINTER_SIZE-1:0] w_end;
    logic [POINTER_SIZE-1:0] w_diff;
    logic [POINTER_SIZE:0]   w_len;
    logic                    w_row_ready;
    logic                    w_wr_ready;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_rel_err;
    logic [POINTER_SIZE:0]   w_cnt_next;
    logic [RW-1:0]           w_rows_next;

    assign w_end       = r_rq[r_head];
    assign w_row_ready = (r_rows != '0);
    assign w_wr_ready  = (r_cnt < DEPTH_C) && (r_rows < RQD_C);
    assign w_accept    = bus.wr_valid && w_wr_ready;
    assign w_push      = w_accept && bus.wr_last;
    assign w_pop       = bus.release_row && w_row_ready;
    assign w_rel_err   = bus.release_row && !w_row_ready;

    // Row length is end-start+1 computed one bit wider, so a row that spans the
    // whole buffer (diff = DEPTH-1) yields DEPTH rather than wrapping to zero.
    assign w_diff = w_end - r_start;
    assign w_len  = {1'b0, w_diff} + CNT_ONE;

    // Next word count and row count when a write and a release coincide.
    always_comb begin
        w_cnt_next  = r_cnt;
        w_rows_next = r_rows;
        if (w_accept) begin
            w_cnt_next = w_cnt_next + CNT_ONE;
        end
        if (w_pop) begin
            w_cnt_next = w_cnt_next - w_len;
        end
        if (w_push && !w_pop) begin
            w_rows_next = r_rows + ROW_ONE;
        end else if (!w_push && w_pop) begin
            w_rows_next = r_rows - ROW_ONE;
        end
    end

    // Write pointer, occupancy, row queue and release bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_cnt   <= '0;
            r_start <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_rows  <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < ROW_QUEUE_DEPTH; i++) begin
                r_rq[i] <= '0;
            end
        end else begin
            r_cnt  <= w_cnt_next;
            r_rows <= w_rows_next;
            if (w_accept) begin
                r_wp <= r_wp + PTR_ONE;
            end
            if (w_push) begin
                r_rq[r_tail] <= r_wp;
                r_tail       <= (r_tail == Q_LAST) ? '0 : r_tail + Q_ONE;
            end
            if (w_pop) begin
                r_start <= w_end + PTR_ONE;
                r_head  <= (r_head == Q_LAST) ? '0 : r_head + Q_ONE;
            end
            if (w_rel_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Buffer write; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wp] <= bus.wr_data;
        end
    end

    // Registered read; a same-cycle write to the same address is not forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_data <= r_mem[bus.read_pointer];
            end
        end
    end

    assign bus.wr_ready    = w_wr_ready;
    assign bus.rd_data     = r_rd_data;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.start_row   = r_start;
    assign bus.end_row     = w_end;
    assign bus.row_ready   = w_row_ready;
    assign bus.rows_stored = r_rows;
    assign bus.err_release = r_err;

endmodule

// File: doc/if_scratchpad.md
# if_scratchpad

Circular input-feature (IF) scratchpad that sits directly downstream of the IF read address generator and upstream of the PE datapath. It accepts IF words row by row from the input FIFO and stores them in a wrap-around buffer. It records the boundaries of complete rows, exports the oldest complete row's start/end pointers to the address generator, and returns registered read data at the generator's read pointer. Rows are freed explicitly by the controller once every window that uses them has been consumed.

## Interface
Parameters:
- DATA_WIDTH, 16, IF word width
- POINTER_SIZE, 8, address width; depth = 2**POINTER_SIZE words
- ROW_QUEUE_DEPTH, 4, maximum number of complete rows held (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_valid  in  1  write word offered
- wr_data  in  DATA_WIDTH  write word
- wr_last  in  1  offered word is the last word of its row
- wr_ready  out  1  scratchpad can accept a word this cycle
- rd_en  in  1  read request
- read_pointer  in  POINTER_SIZE  read address from the address generator
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  1  rd_data holds the result of last cycle's rd_en
- release_row  in  1  pulse: free the oldest complete row
- start_row  out  POINTER_SIZE  address of the first word of the oldest complete row
- end_row  out  POINTER_SIZE  address of the last word of the oldest complete row
- row_ready  out  1  at least one complete row is stored
- rows_stored  out  $clog2(ROW_QUEUE_DEPTH)+1  number of complete rows held
- err_release  out  1  sticky: release_row arrived with row_ready=0

## Operation
- Storage: DEPTH x DATA_WIDTH array. Write pointer wp and word count cnt (width POINTER_SIZE+1). All pointer arithmetic is mod 2**POINTER_SIZE.
- Write accept: wr_valid && wr_ready. The word is stored at wp, then wp increments and cnt increments.
- wr_ready = (cnt < DEPTH) && (rows_stored < ROW_QUEUE_DEPTH). The signal is combinational from registers and does not depend on wr_valid.
- Row completion: on an accepted write with wr_last=1, wp (the address just written) is pushed into the row-end queue and rows_stored increments.
- start_row is a register pointing at the first word of the oldest unreleased row. end_row is the row-end queue head.
- row_ready = (rows_stored != 0).
- Release: release_row with row_ready=1 does the following in one cycle:
  - pop the queue head;
  - start_row <= end_row + 1;
  - cnt decrements by row length = end_row - start_row + 1 (mod DEPTH; a row of exactly DEPTH words yields length DEPTH);
  - rows_stored decrements.
- Release with row_ready=0 is ignored and sets err_release. err_release is cleared only by rst.
- Simultaneous accepted write and release: both take effect in the same cycle. The net cnt is cnt + 1 - length. rows_stored changes by (+1 if wr_last) - 1. Queue push and pop occur together.
- Partial row: words written without wr_last occupy cnt but are not visible via row_ready/end_row.
- Read: rd_en samples mem[read_pointer] into rd_data. Reads are not checked against row boundaries; the controller reads only within complete rows.
- Read of the address being written in the same cycle returns the old content.

## Timing
- Reset values:
  - wp=0, cnt=0, start_row=0, end_row=0, rows_stored=0, row_ready=0;
  - rd_data=0, rd_valid=0, err_release=0;
  - wr_ready=1 (combinational).
- Memory contents are not reset.
- Write visibility: a row whose last word is accepted at edge N has row_ready=1 and a valid end_row from edge N onward, so the generator can start in cycle N+1.
- Read latency is 1 cycle. rd_en at edge N gives rd_data/rd_valid at edge N. rd_valid=0 when rd_en was low; rd_data holds its last value.
- Release: start_row/end_row/rows_stored reflect the next row after the release edge. wr_ready may rise in the same following cycle.
- Reset mid-operation discards all rows and partial data immediately. Outputs take their reset values asynchronously.

## Test plan
- Single row: write 5 words (wr_last on the 5th) from reset -> start_row=0, end_row=4, row_ready=1, rows_stored=1. Reads at 0..4 return the written data one cycle later with rd_valid=1.
- Fill to full, with POINTER_SIZE=4 (DEPTH=16):
  - write rows of 8+8 -> wr_ready=0 with cnt=16;
  - release_row -> start_row=8, end_row=15, wr_ready=1.
- Wrap-around, DEPTH=16: after the previous step, write a 6-word row -> end_row after the next release = 5. Reading start_row+k for k=0..5 with 4-bit wrap returns the correct words.
- Row-queue full, ROW_QUEUE_DEPTH=4: write four 2-word rows -> wr_ready=0 at cnt=8. A 5th row waits until release_row.
- Simultaneous: with one 3-word row stored, drive release_row in the same cycle as accepting the wr_last word of a second row -> rows_stored stays 1 and start_row=3. cnt equals the second row length.
- Errors and reset:
  - release_row from reset -> err_release=1 and all other state unchanged;
  - assert rst mid-row -> all outputs return to reset values asynchronously.
